segre_mem_arbiter: RTL and testbench
====================================

SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_SIZE, 32, address width; LANE_SIZE, 128, cache lane width in bits; WORD_SIZE, 32, store data width; TIMEOUT_CYCLES, 64, watchdog limit.
REQ-002 The block SHALL use one clock and a synchronous active-low reset, with these ports:
- clk_i  in  1  clock
- rsn_i  in  1  synchronous active-low reset
- dc_req_i  in  1  dcache lane refill request
- dc_addr_i  in  ADDR_SIZE  dcache miss address
- dc_done_o  out  1  dcache refill complete, one-cycle pulse
- ic_req_i  in  1  icache lane refill request
- ic_addr_i  in  ADDR_SIZE  icache miss address
- ic_done_o  out  1  icache refill complete, one-cycle pulse
- sb_req_i  in  1  store-buffer drain request
- sb_addr_i  in  ADDR_SIZE  store address
- sb_data_i  in  WORD_SIZE  store data
- sb_type_i  in  2  memop_data_type_e of the store
- sb_done_o  out  1  store accepted by memory, one-cycle pulse
- lane_data_o  out  LANE_SIZE  refill data, valid when dc_done_o or ic_done_o is high
- mem_rd_o  out  1  memory read strobe
- mem_wr_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_SIZE  memory address
- mem_wr_data_o  out  WORD_SIZE  memory write data
- mem_type_o  out  2  memory write size
- mem_ready_i  in  1  memory completion, one-cycle pulse
- mem_rd_data_i  in  LANE_SIZE  memory read data, valid with mem_ready_i
- timeout_o  out  1  watchdog error flag (see Configuration)

Function
REQ-003 The block SHALL implement an FSM with states ARB_IDLE, ARB_REQ and ARB_WAIT.
REQ-004 In ARB_IDLE, if any request is high, the block SHALL latch the grant, address, data and type, then go to ARB_REQ; otherwise it SHALL stay in ARB_IDLE.
REQ-005 Arbitration SHALL be round-robin over the order dc -> ic -> sb; a 2-bit last-grant pointer SHALL start at sb after reset, so dc wins the first simultaneous request.
REQ-006 In ARB_REQ, the block SHALL assert mem_rd_o (dc/ic grant) or mem_wr_o (sb grant) for exactly one cycle, then go to ARB_WAIT.
REQ-007 Read addresses SHALL be lane-aligned: the low $clog2(LANE_SIZE/8) bits of mem_addr_o SHALL be 0. Write addresses SHALL pass through unmodified.
REQ-008 In ARB_WAIT, on mem_ready_i the block SHALL pulse the granted requester's done output in the same cycle, drive lane_data_o = mem_rd_data_i (reads only), update the pointer and return to ARB_IDLE.
REQ-009 A mem_ready_i pulse while in ARB_IDLE or ARB_REQ SHALL be ignored.
REQ-010 Requesters SHALL hold req and operands stable until their done pulse; the block SHALL sample operands only on the ARB_IDLE->ARB_REQ transition.
REQ-011 Minimum latency SHALL be 3 cycles from request to done (IDLE, REQ, and WAIT with mem_ready_i arriving in the first WAIT cycle); back-to-back grants SHALL have one ARB_IDLE cycle between them.
REQ-012 At most one done output SHALL be high in any cycle, and mem_rd_o and mem_wr_o SHALL never be high together.

Reset
REQ-013 While rsn_i is low at a clock edge, the FSM SHALL go to ARB_IDLE and the pointer to sb; all outputs SHALL be 0, including lane_data_o and mem_addr_o.
REQ-014 Reset during ARB_WAIT SHALL abort the transaction with no done pulse; a later mem_ready_i SHALL be ignored.

Configuration
REQ-015 With SEGRE_MEM_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in ARB_WAIT; when it reaches TIMEOUT_CYCLES, timeout_o SHALL be set (sticky until reset), the block SHALL pulse the granted done with lane_data_o = 0, and it SHALL return to ARB_IDLE.
REQ-016 Without SEGRE_MEM_ARB_TIMEOUT_EN, no counter SHALL be built, ARB_WAIT SHALL wait indefinitely, and timeout_o SHALL be tied to 0.

Verification
REQ-017 dc_req_i=1 with dc_addr_i=0x0000_1234, mem_ready_i one cycle after mem_rd_o -> mem_addr_o=0x0000_1230, dc_done_o pulses with lane_data_o=mem_rd_data_i.
REQ-018 dc, ic and sb all requesting continuously -> grant order dc, ic, sb, dc; exactly one done per transaction.
REQ-019 sb_req_i with addr 0x0000_0102, data 0xDEAD_BEEF, type HALF -> one-cycle mem_wr_o with the same addr, data and type; sb_done_o on mem_ready_i.
REQ-020 rsn_i low during ARB_WAIT, then mem_ready_i -> no done pulse, all outputs 0, FSM in ARB_IDLE.
REQ-021 With SEGRE_MEM_ARB_TIMEOUT_EN and mem_ready_i never asserted -> after 64 WAIT cycles, timeout_o=1 and the granted done pulses; without the macro -> the FSM stays in ARB_WAIT and timeout_o=0.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter
//   Arbitrates three requesters onto one memory port. The requesters are the
//   dcache lane refill, the icache lane refill and the store-buffer drain.
//   Grants rotate round-robin in the order dc -> ic -> sb. Each transaction
//   runs IDLE -> REQ -> WAIT and completes when mem_ready_i pulses.
//
// Ports
//   clk_i, rsn_i                      clock, synchronous active-low reset
//   dc_req_i/dc_addr_i/dc_done_o      dcache refill request / address / done
//   ic_req_i/ic_addr_i/ic_done_o      icache refill request / address / done
//   sb_req_i/sb_addr_i/sb_data_i/
//   sb_type_i/sb_done_o               store drain request / operands / done
//   lane_data_o                       refill data, valid with dc/ic done
//   mem_rd_o/mem_wr_o                 one-cycle memory strobes
//   mem_addr_o/mem_wr_data_o/
//   mem_type_o                        memory request operands
//   mem_ready_i/mem_rd_data_i         memory completion pulse and read lane
//   timeout_o                         sticky watchdog error flag
//
// Build option
//   SEGRE_MEM_ARB_TIMEOUT_EN enables the ARB_WAIT watchdog. When the macro
//   is undefined, WAIT never times out and timeout_o is tied to 0.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE      = 32,
    parameter int LANE_SIZE      = 128,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 dc_req_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    output logic                 dc_done_o,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_done_o,
    input  logic                 sb_req_i,
    input  logic [ADDR_SIZE-1:0] sb_addr_i,
    input  logic [WORD_SIZE-1:0] sb_data_i,
    input  logic [1:0]           sb_type_i,
    output logic                 sb_done_o,
    output logic [LANE_SIZE-1:0] lane_data_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wr_data_o,
    output logic [1:0]           mem_type_o,
    input  logic                 mem_ready_i,
    input  logic [LANE_SIZE-1:0] mem_rd_data_i,
    output logic                 timeout_o
);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_WAIT = 2'd2;

    localparam logic [1:0] GNT_DC = 2'd0;
    localparam logic [1:0] GNT_IC = 2'd1;
    localparam logic [1:0] GNT_SB = 2'd2;

    localparam int OFF_W = $clog2(LANE_SIZE / 8);

    logic [1:0]           state_q;
    logic [1:0]           last_q;   // last granted requester
    logic [1:0]           gnt_q;    // requester owning the current transaction
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [1:0]           type_q;
    logic [1:0]           gnt_next;
    logic                 any_req;
    logic                 to_hit;
    logic                 finish;
    logic                 gnt_rd;

    // Round-robin pick: start searching just after the last winner.
    always_comb begin
        gnt_next = GNT_SB;
        any_req  = dc_req_i | ic_req_i | sb_req_i;
        case (last_q)
            GNT_DC: begin
                if      (ic_req_i) gnt_next = GNT_IC;
                else if (sb_req_i) gnt_next = GNT_SB;
                else               gnt_next = GNT_DC;
            end
            GNT_IC: begin
                if      (sb_req_i) gnt_next = GNT_SB;
                else if (dc_req_i) gnt_next = GNT_DC;
                else               gnt_next = GNT_IC;
            end
            default: begin
                if      (dc_req_i) gnt_next = GNT_DC;
                else if (ic_req_i) gnt_next = GNT_IC;
                else               gnt_next = GNT_SB;
            end
        endcase
    end

`ifdef SEGRE_MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    // wait_cnt_q is 0 in the first WAIT cycle, so the hit lands on the
    // TIMEOUT_CYCLES-th WAIT cycle. A real completion in that cycle wins.
    assign to_hit = (state_q == ARB_WAIT) && !mem_ready_i &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == ARB_WAIT) ? wait_cnt_q + 1'b1 : '0;
            if (to_hit) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q <= ARB_IDLE;
            last_q  <= GNT_SB;
            gnt_q   <= GNT_DC;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= gnt_next;
                        state_q <= ARB_REQ;
                        case (gnt_next)
                            GNT_DC: begin
                                addr_q <= {dc_addr_i[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                                data_q <= '0;
                                type_q <= '0;
                            end
                            GNT_IC: begin
                                addr_q <= {ic_addr_i[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                                data_q <= '0;
                                type_q <= '0;
                            end
                            default: begin
                                addr_q <= sb_addr_i;
                                data_q <= sb_data_i;
                                type_q <= sb_type_i;
                            end
                        endcase
                    end
                end
                ARB_REQ:  state_q <= ARB_WAIT;
                ARB_WAIT: begin
                    if (mem_ready_i || to_hit) begin
                        last_q  <= gnt_q;
                        state_q <= ARB_IDLE;
                    end
                end
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

    // Combinational outputs are gated by rsn_i. This keeps them at 0 in the
    // reset cycle, before the registered state has been cleared.
    assign gnt_rd = (gnt_q != GNT_SB);
    assign finish = rsn_i && (state_q == ARB_WAIT) && (mem_ready_i || to_hit);

    assign dc_done_o = finish && (gnt_q == GNT_DC);
    assign ic_done_o = finish && (gnt_q == GNT_IC);
    assign sb_done_o = finish && (gnt_q == GNT_SB);

    assign lane_data_o = (finish && mem_ready_i && gnt_rd) ? mem_rd_data_i : '0;

    assign mem_rd_o      = rsn_i && (state_q == ARB_REQ) && gnt_rd;
    assign mem_wr_o      = rsn_i && (state_q == ARB_REQ) && !gnt_rd;
    assign mem_addr_o    = addr_q;
    assign mem_wr_data_o = data_q;
    assign mem_type_o    = type_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
module tb_segre_mem_arbiter;
    localparam int AW = 32, LW = 128, WW = 32, TO = 64;

    logic          clk_i = 1'b0, rsn_i = 1'b0;
    logic [2:0]    req = '0;                 // bit0 dc, bit1 ic, bit2 sb
    logic [AW-1:0] r_addr [3];
    logic [WW-1:0] r_data [3];
    logic [1:0]    r_type [3];
    logic          mem_ready_i = 1'b0;
    logic [LW-1:0] mem_rd_data_i = '0;
    logic          dc_done_o, ic_done_o, sb_done_o, mem_rd_o, mem_wr_o, timeout_o;
    logic [LW-1:0] lane_data_o;
    logic [AW-1:0] mem_addr_o;
    logic [WW-1:0] mem_wr_data_o;
    logic [1:0]    mem_type_o;

    always #5 clk_i = ~clk_i;

    segre_mem_arbiter #(.ADDR_SIZE(AW), .LANE_SIZE(LW), .WORD_SIZE(WW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .dc_req_i(req[0]), .dc_addr_i(r_addr[0]), .dc_done_o(dc_done_o),
        .ic_req_i(req[1]), .ic_addr_i(r_addr[1]), .ic_done_o(ic_done_o),
        .sb_req_i(req[2]), .sb_addr_i(r_addr[2]), .sb_data_i(r_data[2]),
        .sb_type_i(r_type[2]), .sb_done_o(sb_done_o),
        .lane_data_o(lane_data_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_type_o(mem_type_o),
        .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i), .timeout_o(timeout_o)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, chosen round-robin from
    // the requesters seen in the cycle the arbiter is free.
    typedef struct {
        int            who;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic [1:0]    typ;
    } txn_t;

    txn_t sb_q[$];
    txn_t pend_t;
    int   grant_log[$];
    bit   pending = 0, active = 0, exp_to = 0;
    int   last = 2, wait_cnt = 0;
    bit   [2:0] clr = '0;
    logic rsn_edge = 1'b0;
    int   raise_pct = 0;
    bit   resp_en = 1, rand_en = 0;
    int   dly = 0;

    always @(posedge clk_i) rsn_edge = rsn_i;

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        if (!rsn_i) begin
            chk("rst_done", {sb_done_o, ic_done_o, dc_done_o}, 0);
            chk("rst_strobe", {mem_rd_o, mem_wr_o}, 0);
            chk("rst_lane", lane_data_o, 0);
            if (!rsn_edge) begin
                chk("rst_addr", mem_addr_o, 0);
                chk("rst_wdata", mem_wr_data_o, 0);
                chk("rst_type", mem_type_o, 0);
                chk("rst_timeout", timeout_o, 0);
            end
            pending = 0; active = 0; exp_to = 0; wait_cnt = 0; last = 2; clr = '0;
            sb_q.delete();
        end else begin : mon
            bit            was_idle, fire;
            logic [2:0]    exp_done;
            logic [LW-1:0] exp_lane;
            txn_t          t;
            was_idle = !pending && !active;
            exp_done = '0;
            exp_lane = '0;
            chk("timeout_flag", timeout_o, exp_to);
            chk("rd_wr_excl", mem_rd_o & mem_wr_o, 0);
            if (pending) begin
                t = pend_t;
                chk("strobe", {mem_rd_o, mem_wr_o}, (t.who == 2) ? 2'b01 : 2'b10);
                chk("addr", mem_addr_o, (t.who == 2) ? t.addr : t.addr - (t.addr % (LW / 8)));
                if (t.who == 2) begin
                    chk("wdata", mem_wr_data_o, t.data);
                    chk("wtype", mem_type_o, t.typ);
                end
                sb_q.push_back(t);
                grant_log.push_back(t.who);
                pending = 0; active = 1; wait_cnt = 0;
            end else begin
                chk("no_strobe", {mem_rd_o, mem_wr_o}, 0);
                if (active) begin
                    wait_cnt++;
                    fire = mem_ready_i;
`ifdef SEGRE_MEM_ARB_TIMEOUT_EN
                    if (!mem_ready_i && wait_cnt == TO) begin
                        fire = 1; exp_to = 1;
                    end
`endif
                    if (fire) begin
                        t = sb_q.pop_front();
                        exp_done = 3'(1 << t.who);
                        if (mem_ready_i && t.who != 2) exp_lane = mem_rd_data_i;
                        last = t.who; active = 0; clr[t.who] = 1'b1;
                    end
                end
            end
            chk("done", {sb_done_o, ic_done_o, dc_done_o}, exp_done);
            chk("lane", lane_data_o, exp_lane);
            if (was_idle && req != 0) begin
                for (int k = 1; k <= 3; k++) begin
                    if (req[(last + k) % 3]) begin
                        pend_t.who = (last + k) % 3;
                        break;
                    end
                end
                pend_t.addr = r_addr[pend_t.who];
                pend_t.data = r_data[pend_t.who];
                pend_t.typ  = r_type[pend_t.who];
                pending = 1;
            end
        end
    end

    // Requester agents: hold req and operands until the done pulse.
    always begin
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            if (clr[i]) begin
                req[i] = 1'b0; clr[i] = 1'b0;
            end else if (!req[i] && rsn_i && $urandom_range(0, 99) < raise_pct) begin
                r_addr[i] = $urandom;
                r_data[i] = $urandom;
                r_type[i] = 2'($urandom_range(0, 2));
                req[i]    = 1'b1;
            end
        end
    end

    // Memory responder with optional random latency and stray pulses.
    always begin
        @(posedge clk_i); #1;
        if (resp_en) begin
            mem_ready_i = 1'b0;
            if (active) begin
                if (dly == 0) begin
                    mem_ready_i   = 1'b1;
                    mem_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
                    dly = rand_en ? $urandom_range(0, 3) : 0;
                end else dly--;
            end else if (rand_en && $urandom_range(0, 9) == 0) begin
                mem_ready_i   = 1'b1;
                mem_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic wait_done(input int who, output int n);
        n = 0;
        do begin
            @(negedge clk_i); n++;
        end while (!(who == 0 ? dc_done_o : who == 1 ? ic_done_o : sb_done_o) && n < 200);
        if (n >= 200) chk("done_wait_bound", 0, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            r_addr[i] = '0; r_data[i] = '0; r_type[i] = '0;
        end
        repeat (3) @(posedge clk_i);
        #1 rsn_i = 1'b1;

        // Single dcache refill: lane-aligned address, 3-cycle latency
        @(posedge clk_i); #1;
        r_addr[0] = 32'h0000_1234; req[0] = 1'b1;
        wait_done(0, n);
        chk("dc_latency", n, 3);

        // Half-word store passes through unmodified
        @(posedge clk_i); #1;
        r_addr[2] = 32'h0000_0102; r_data[2] = 32'hDEAD_BEEF; r_type[2] = 2'b01; req[2] = 1'b1;
        wait_done(2, n);
        chk("sb_latency", n, 3);

        // All three requesting continuously: dc, ic, sb, dc
        grant_log.delete();
        raise_pct = 100;
        n = 0;
        while (grant_log.size() < 4 && n < 100) begin
            @(negedge clk_i); n++;
        end
        raise_pct = 0;
        chk("rr_count", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 2);
            chk("rr_g3", grant_log[3], 0);
        end
        n = 0;
        while ((req != 0 || active || pending) && n < 100) begin
            @(negedge clk_i); n++;
        end
        chk("rr_drain", req, 0);

        // Reset in WAIT aborts; a late mem_ready_i is ignored
        resp_en = 0; mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        r_addr[0] = 32'h0000_4444; req[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i); n++;
        end while (!mem_rd_o && n < 20);
        chk("abort_strobe_seen", mem_rd_o, 1);
        @(posedge clk_i); #1;
        rsn_i = 1'b0; req = '0;
        repeat (2) @(posedge clk_i);
        #1 rsn_i = 1'b1;
        mem_ready_i = 1'b1; mem_rd_data_i = {4{32'hA5A5_5A5A}};
        @(negedge clk_i);
        chk("abort_no_done", {sb_done_o, ic_done_o, dc_done_o}, 0);
        chk("abort_addr", mem_addr_o, 0);
        chk("abort_lane", lane_data_o, 0);
        @(posedge clk_i); #1 mem_ready_i = 1'b0;

        // Memory never answers
        @(posedge clk_i); #1;
        r_addr[1] = 32'h0000_8888; req[1] = 1'b1;
`ifdef SEGRE_MEM_ARB_TIMEOUT_EN
        wait_done(1, n);
        chk("to_latency", n, 2 + TO);
        @(negedge clk_i);
        chk("to_sticky", timeout_o, 1);
`else
        repeat (80) @(negedge clk_i);
        chk("no_to_flag", timeout_o, 0);
        chk("no_to_done", ic_done_o, 0);
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1; mem_rd_data_i = {4{32'h1357_9BDF}};
        @(negedge clk_i);
        chk("late_ic_done", ic_done_o, 1);
        @(posedge clk_i); #1 mem_ready_i = 1'b0;
`endif

        // Random traffic
        resp_en = 1; rand_en = 1; raise_pct = 30;
        repeat (1500) @(posedge clk_i);
        raise_pct = 0;
        n = 0;
        while ((req != 0 || active || pending) && n < 300) begin
            @(negedge clk_i); n++;
        end
        chk("final_drain", {req, active, pending}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
